// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared widths, the register-0 index and the arbiter grant encoding for the
// write-back arbiter slice.
package regfile_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NREG     = 2 ** ADDR_W;
    localparam int REG_ZERO = 0;

    // Identity of the requester that won the most recent transfer.
    typedef enum logic {
        GRANT_REQ0 = 1'b0,
        GRANT_REQ1 = 1'b1
    } grant_e;

endpackage : regfile_pkg

// File: rtl/regfile_wb_arbiter_if.sv
// Valid/ready write-back handshake for the two requesters (ALU path and
// load/multi-cycle path) feeding the register-file arbiter.
interface regfile_wb_arbiter_if #(
    parameter int DATA_W = regfile_pkg::DATA_W,
    parameter int ADDR_W = regfile_pkg::ADDR_W
);

    logic              req0Valid;
    logic              req0Ready;
    logic [ADDR_W-1:0] req0Addr;
    logic [DATA_W-1:0] req0Data;

    logic              req1Valid;
    logic              req1Ready;
    logic [ADDR_W-1:0] req1Addr;
    logic [DATA_W-1:0] req1Data;

    modport master (
        output req0Valid, req0Addr, req0Data,
        output req1Valid, req1Addr, req1Data,
        input  req0Ready, req1Ready
    );

    modport slave (
        input  req0Valid, req0Addr, req0Data,
        input  req1Valid, req1Addr, req1Data,
        output req0Ready, req1Ready
    );

endinterface : regfile_wb_arbiter_if

// File: rtl/regfile_wb_arbiter_rr_arbiter2.sv
// Two-input round-robin arbiter: a lone request always wins, contention goes
// to the requester that did not win last time.
module rr_arbiter2
    import regfile_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic valid0_i,
    input  logic valid1_i,
    output logic grant0_o,
    output logic grant1_o,
    output logic update_o
);

    grant_e lastGrant_q;
    grant_e lastGrant_d;

    // Resetting to REQ1 lets requester 0 win the first contention.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lastGrant_q <= GRANT_REQ1;
        end else begin
            lastGrant_q <= lastGrant_d;
        end
    end

    always_comb begin
        grant0_o    = 1'b0;
        grant1_o    = 1'b0;
        update_o    = 1'b0;
        lastGrant_d = lastGrant_q;

        unique case ({valid1_i, valid0_i})
            2'b01: grant0_o = 1'b1;
            2'b10: grant1_o = 1'b1;
            2'b11: begin
                if (lastGrant_q == GRANT_REQ1) begin
                    grant0_o = 1'b1;
                end else begin
                    grant1_o = 1'b1;
                end
            end
            default: ;
        endcase

        // Ready equals grant, so every grant is a transfer this cycle.
        update_o = grant0_o | grant1_o;
        if (grant1_o) begin
            lastGrant_d = GRANT_REQ1;
        end else if (grant0_o) begin
            lastGrant_d = GRANT_REQ0;
        end
    end

endmodule : rr_arbiter2

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the single register-file write port plus the
// pending-write scoreboard that decode uses for RAW/WAW stalls.
module regfile_wb_arbiter #(
    parameter int DATA_W = regfile_pkg::DATA_W,
    parameter int ADDR_W = regfile_pkg::ADDR_W
) (
    input  logic                clk,
    input  logic                rst_n,

    regfile_wb_arbiter_if.slave req_if,

    output logic                regWrite,
    output logic [ADDR_W-1:0]   writeRegister,
    output logic [DATA_W-1:0]   writeData,

    input  logic                issueValid,
    input  logic [ADDR_W-1:0]   issueAddr,
    output logic                issueBusy,

    input  logic [ADDR_W-1:0]   readRegister1,
    input  logic [ADDR_W-1:0]   readRegister2,
    output logic                rdBusy1,
    output logic                rdBusy2
);

    import regfile_pkg::*;

    localparam int NUM_REGS = 2 ** ADDR_W;

    function automatic logic is_reg0(input logic [ADDR_W-1:0] addr);
        return addr == ADDR_W'(REG_ZERO);
    endfunction

    logic grant0;
    logic grant1;
    logic xfer;

    logic [ADDR_W-1:0]   selAddr;
    logic [DATA_W-1:0]   selData;

    logic                regWrite_q;
    logic                regWrite_d;
    logic [ADDR_W-1:0]   writeRegister_q;
    logic [ADDR_W-1:0]   writeRegister_d;
    logic [DATA_W-1:0]   writeData_q;
    logic [DATA_W-1:0]   writeData_d;

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;

    rr_arbiter2 u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .valid0_i (req_if.req0Valid),
        .valid1_i (req_if.req1Valid),
        .grant0_o (grant0),
        .grant1_o (grant1),
        .update_o (xfer)
    );

    assign req_if.req0Ready = grant0;
    assign req_if.req1Ready = grant1;

    always_comb begin
        selAddr = req_if.req0Addr;
        selData = req_if.req0Data;
        if (grant1) begin
            selAddr = req_if.req1Addr;
            selData = req_if.req1Data;
        end
    end

    // Output stage: a register-0 write is accepted and consumed here but never
    // raises the write enable; address and data hold when nothing transfers.
    always_comb begin
        regWrite_d      = xfer && !is_reg0(selAddr);
        writeRegister_d = writeRegister_q;
        writeData_d     = writeData_q;
        if (xfer) begin
            writeRegister_d = selAddr;
            writeData_d     = selData;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regWrite_q      <= 1'b0;
            writeRegister_q <= '0;
            writeData_q     <= '0;
        end else begin
            regWrite_q      <= regWrite_d;
            writeRegister_q <= writeRegister_d;
            writeData_q     <= writeData_d;
        end
    end

    assign regWrite      = regWrite_q;
    assign writeRegister = writeRegister_q;
    assign writeData     = writeData_q;

    // Scoreboard: the commit clear is applied first so that an issue to the
    // same register at the same edge leaves it marked in flight.
    always_comb begin
        busy_d = busy_q;
        if (regWrite_q) begin
            busy_d[writeRegister_q] = 1'b0;
        end
        if (issueValid && !is_reg0(issueAddr)) begin
            busy_d[issueAddr] = 1'b1;
        end
        busy_d[REG_ZERO] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // Lookups see only the registered state: no bypass of an in-cycle commit.
    assign issueBusy = busy_q[issueAddr];
    assign rdBusy1   = busy_q[readRegister1];
    assign rdBusy2   = busy_q[readRegister2];

endmodule : regfile_wb_arbiter
